mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mult_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: keypad-driven operand entry and sequencing for an external
// 8x8 multiplier. Operands are typed as decimal digits, Enter advances from
// operand A to operand B and then launches the multiply; the product is shown
// until a new digit, Enter (re-multiply) or clear-all arrives.
//
// Optional feature: define SEQ_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT_CYCLES clocks and a sticky ERROR state (display 16'hFFFF).
module mult_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_pressed,
  input  logic [3:0]  key_value,
  input  logic        mult_done,
  input  logic [15:0] mult_y,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        mult_start,
  output logic [15:0] display_value,
  output logic [3:0]  state_led,
  output logic        err
);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_START,
    S_WAIT,
    S_SHOW
`ifdef SEQ_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  // Phase indicator codes; START shares the WAIT indicator since it lasts
  // a single cycle on the way into WAIT.
  localparam logic [3:0] LED_A     = 4'b0001;
  localparam logic [3:0] LED_B     = 4'b0010;
  localparam logic [3:0] LED_WAIT  = 4'b0100;
  localparam logic [3:0] LED_SHOW  = 4'b1000;
`ifdef SEQ_TIMEOUT_EN
  localparam logic [3:0] LED_ERROR = 4'b1111;
  localparam int         WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t state;
  logic   key_d;
`ifdef SEQ_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
`endif

  // Key decode: a key acts only on the rising edge of key_pressed.
  logic key_evt;
  logic ev_digit;
  logic ev_enter;
  logic ev_clear_entry;
  logic ev_clear_all;

  assign key_evt        = key_pressed & ~key_d;
  assign ev_digit       = key_evt & (key_value <= 4'd9);
  assign ev_enter       = key_evt & (key_value == 4'hA);
  assign ev_clear_entry = key_evt & (key_value == 4'hB);
  assign ev_clear_all   = key_evt & (key_value == 4'hC);

  // Decimal accumulate in 16 bits so an overflow past 255 is visible.
  logic [15:0] a_wide;
  logic [15:0] b_wide;
  logic        a_ovf;
  logic        b_ovf;

  assign a_wide = {8'd0, op_a} * 16'd10 + {12'd0, key_value};
  assign b_wide = {8'd0, op_b} * 16'd10 + {12'd0, key_value};
  assign a_ovf  = a_wide > 16'd255;
  assign b_ovf  = b_wide > 16'd255;

  // Key-edge register, sequencer FSM, operands and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here -- rst is sampled at the clock edge
    // like any other input, so every register is listed in this branch.
    if (!rst) begin
      state         <= S_ENTER_A;
      state_led     <= LED_A;
      key_d         <= 1'b0;
      op_a          <= 8'd0;
      op_b          <= 8'd0;
      display_value <= 16'd0;
      mult_start    <= 1'b0;
      err           <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of op_a/op_b/state.
      key_d      <= key_pressed;
      mult_start <= 1'b0;

      if (ev_clear_all) begin
        // Clear-all wins over everything, including a same-cycle mult_done.
        state         <= S_ENTER_A;
        state_led     <= LED_A;
        op_a          <= 8'd0;
        op_b          <= 8'd0;
        display_value <= 16'd0;
        err           <= 1'b0;
      end else begin
        unique case (state)
          S_ENTER_A: begin
            display_value <= {8'd0, op_a};
            if (ev_digit) begin
              if (a_ovf) err  <= 1'b1;
              else       op_a <= a_wide[7:0];
            end else if (ev_enter) begin
              state     <= S_ENTER_B;
              state_led <= LED_B;
              op_b      <= 8'd0;
            end else if (ev_clear_entry) begin
              op_a <= 8'd0;
            end
          end

          S_ENTER_B: begin
            display_value <= {8'd0, op_b};
            if (ev_digit) begin
              if (b_ovf) err  <= 1'b1;
              else       op_b <= b_wide[7:0];
            end else if (ev_enter) begin
              state      <= S_START;
              state_led  <= LED_WAIT;
              mult_start <= 1'b1;
            end else if (ev_clear_entry) begin
              op_b <= 8'd0;
            end
          end

          S_START: begin
            state <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end

          S_WAIT: begin
            if (mult_done) begin
              display_value <= mult_y;
              state         <= S_SHOW;
              state_led     <= LED_SHOW;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wd_cnt == WD_LAST) begin
              state         <= S_ERROR;
              state_led     <= LED_ERROR;
              err           <= 1'b1;
              display_value <= 16'hFFFF;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
`endif
          end

          S_SHOW: begin
            if (ev_digit) begin
              op_a      <= {4'd0, key_value};
              op_b      <= 8'd0;
              state     <= S_ENTER_A;
              state_led <= LED_A;
            end else if (ev_enter) begin
              state      <= S_START;
              state_led  <= LED_WAIT;
              mult_start <= 1'b1;
            end
          end

`ifdef SEQ_TIMEOUT_EN
          S_ERROR: begin
            // Held until clear-all or reset.
            state_led <= LED_ERROR;
          end
`endif

          default: begin
            state     <= S_ENTER_A;
            state_led <= LED_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed scenarios plus randomized
// calculations, compared against a key-level behavioural model. The bench also
// plays the multiplier, answering each start pulse after a chosen delay.
module tb_mult_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_pressed;
  logic [3:0]  key_value;
  logic        mult_done;
  logic [15:0] mult_y;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        mult_start;
  logic [15:0] display_value;
  logic [3:0]  state_led;
  logic        err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int start_a = 0;
  int start_b = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_pressed   (key_pressed),
    .key_value     (key_value),
    .mult_done     (mult_done),
    .mult_y        (mult_y),
    .op_a          (op_a),
    .op_b          (op_b),
    .mult_start    (mult_start),
    .display_value (display_value),
    .state_led     (state_led),
    .err           (err)
  );

  // Count start pulses (a stretched pulse counts twice) and note the operands
  // presented with each one.
  always @(negedge clk) begin
    if (mult_start) begin
      start_cnt++;
      start_a = op_a;
      start_b = op_b;
    end
  end

  // Behavioural model: calculator state after each complete key press.
  typedef enum {M_A, M_B, M_WAIT, M_SHOW, M_ERR} mstate_t;
  mstate_t m_state;
  int      m_a;
  int      m_b;
  int      m_disp;
  bit      m_err;

  function automatic logic [3:0] led_of(input mstate_t s);
    case (s)
      M_A:     return 4'b0001;
      M_B:     return 4'b0010;
      M_WAIT:  return 4'b0100;
      M_SHOW:  return 4'b1000;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic model_clear();
    m_state = M_A;
    m_a = 0;
    m_b = 0;
    m_disp = 0;
    m_err = 1'b0;
  endtask

  task automatic model_key(input int k);
    int cur;
    if (k == 12) begin
      model_clear();
    end else if (m_state == M_A || m_state == M_B) begin
      cur = (m_state == M_A) ? m_a : m_b;
      if (k <= 9) begin
        if (cur * 10 + k > 255) m_err = 1'b1;
        else cur = cur * 10 + k;
      end else if (k == 11) begin
        cur = 0;
      end
      if (m_state == M_A) m_a = cur;
      else m_b = cur;
      if (k == 10) begin
        if (m_state == M_A) begin
          m_state = M_B;
          m_b = 0;
        end else begin
          m_state = M_WAIT;
        end
      end
      if (m_state == M_A) m_disp = m_a;
      else if (m_state == M_B) m_disp = m_b;
    end else if (m_state == M_SHOW) begin
      if (k <= 9) begin
        m_state = M_A;
        m_a = k;
        m_b = 0;
        m_disp = k;
      end else if (k == 10) begin
        m_state = M_WAIT;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable against the model (display is unspecified in WAIT).
  task automatic check_all(input string tag);
    check({tag, "/op_a"}, op_a, m_a);
    check({tag, "/op_b"}, op_b, m_b);
    check({tag, "/led"}, state_led, led_of(m_state));
    check({tag, "/err"}, err, m_err);
    if (m_state != M_WAIT) check({tag, "/disp"}, display_value, m_disp);
  endtask

  task automatic press(input int k, input int hold);
    @(negedge clk);
    key_pressed = 1'b1;
    key_value   = k[3:0];
    repeat (hold) @(negedge clk);
    key_pressed = 1'b0;
    key_value   = 4'($urandom);
    repeat (3) @(negedge clk);
    model_key(k);
  endtask

  task automatic press_seq(input int keys[$]);
    foreach (keys[i]) press(keys[i], 1);
  endtask

  // Act as the multiplier: mult_done for one cycle after 'delay' cycles.
  task automatic respond(input int delay, input logic [15:0] y);
    repeat (delay) @(negedge clk);
    mult_done = 1'b1;
    mult_y    = y;
    @(negedge clk);
    mult_done = 1'b0;
    mult_y    = 16'($urandom);
    repeat (2) @(negedge clk);
    if (m_state == M_WAIT) begin
      m_state = M_SHOW;
      m_disp  = y;
    end
  endtask

  function automatic int rand_key();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10) return r;
    if (r == 10) return 11;
    return 13 + $urandom_range(0, 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int nd;
    logic [15:0] prod;

    rst = 1'b0;
    key_pressed = 1'b0;
    key_value = 4'd0;
    mult_done = 1'b0;
    mult_y = 16'd0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check_all("reset");
    check("reset/start", mult_start, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 12 x 10 = 120
    press_seq('{12, 1, 2, 10, 1, 0});
    check_all("entry_12_10");
    s0 = start_cnt;
    press(10, 1);
    check("mul/start_pulses", start_cnt, s0 + 1);
    check("mul/start_a", start_a, 12);
    check("mul/start_b", start_b, 10);
    check_all("mul/wait");
    respond(5, 16'd120);
    check_all("mul/show");
    check("mul/disp120", display_value, 16'd120);

    // Re-multiply from SHOW with unchanged operands
    s0 = start_cnt;
    press(10, 2);
    check("remul/start_pulses", start_cnt, s0 + 1);
    check_all("remul/wait");
    respond(2, 16'd120);
    check_all("remul/show");

    // Digit in SHOW starts a new calculation
    press(3, 1);
    check_all("show_digit");

    // Overflow clamp, then clear-all
    press_seq('{12, 2, 5, 6});
    check_all("ovf");
    check("ovf/err", err, 1'b1);
    press(14, 1);
    check_all("ignored_key");
    respond(1, 16'hBEEF);
    check_all("done_outside_wait");
    press(11, 1);
    check_all("clear_entry");
    press(12, 1);
    check_all("clear_all");

    // Held key is a single event
    press(7, 1000);
    check_all("hold7");
    check("hold7/op_a", op_a, 8'd7);

    // Keys other than clear-all are ignored in WAIT
    press_seq('{12, 3, 10, 4});
    s0 = start_cnt;
    press(10, 1);
    press_seq('{5, 11, 10});
    check("wait_keys/start_pulses", start_cnt, s0 + 1);
    check_all("wait_keys");
    respond(3, 16'd12);
    check_all("wait_keys/show");

    // Clear-all and mult_done in the same cycle: clear-all wins
    press_seq('{12, 3, 10, 4, 10});
    @(negedge clk);
    key_pressed = 1'b1;
    key_value = 4'hC;
    mult_done = 1'b1;
    mult_y = 16'd12;
    @(negedge clk);
    mult_done = 1'b0;
    key_pressed = 1'b0;
    repeat (3) @(negedge clk);
    model_key(12);
    check_all("clr_vs_done");

    // Reset during WAIT discards the pending product
    press_seq('{9, 10, 9, 10});
    check_all("rst_wait/pre");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    respond(2, 16'd81);
    check_all("rst_wait/post");
    check("rst_wait/start", mult_start, 1'b0);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: no mult_done -> ERROR after TIMEOUT WAIT cycles
    press_seq('{6, 10, 7, 10});
    repeat (6) @(negedge clk);
    check_all("wd/still_wait");
    repeat (TIMEOUT) @(negedge clk);
    m_state = M_ERR;
    m_err = 1'b1;
    m_disp = 16'hFFFF;
    check_all("wd/error");
    press_seq('{3, 10});
    check_all("wd/error_sticky");
    press(12, 1);
    check_all("wd/cleared");
`else
    // Without the watchdog, WAIT persists until mult_done
    press_seq('{6, 10, 7, 10});
    repeat (4 * TIMEOUT) @(negedge clk);
    check_all("nowd/still_wait");
    respond(1, 16'd42);
    check_all("nowd/show");
    press(12, 1);
`endif

    // Randomized calculations
    for (int it = 0; it < 25; it++) begin
      press(12, 1);
      nd = $urandom_range(1, 4);
      for (int d = 0; d < nd; d++) press(rand_key(), $urandom_range(1, 3));
      press(10, $urandom_range(1, 3));
      nd = $urandom_range(1, 4);
      for (int d = 0; d < nd; d++) press(rand_key(), $urandom_range(1, 3));
      check_all("rand/entry");
      s0 = start_cnt;
      press(10, $urandom_range(1, 3));
      check("rand/start_pulses", start_cnt, s0 + 1);
      check("rand/start_a", start_a, m_a);
      check("rand/start_b", start_b, m_b);
      prod = 16'(m_a * m_b);
      respond($urandom_range(1, 8), prod);
      check_all("rand/show");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
